// File: rtl/ascii_scanner_pkg.sv
// rtl/ascii_scanner_pkg.sv - shared state encoding and ASCII constants for the ascii_scanner slice
package ascii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_LOAD,
        ST_CONVERT,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

endpackage

// File: rtl/ascii_scanner_if.sv
// rtl/ascii_scanner_if.sv - data-memory read port and character-buffer write port bundle
interface ascii_scanner_if #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5,
    parameter int WORDS  = 32
);
    localparam int MAW = $clog2(WORDS);
    localparam int CAW = $clog2(WORDS * (DIGITS + 1));

    logic [MAW-1:0]    mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [CAW-1:0]    char_addr;
    logic [7:0]        char_data;
    logic              char_we;

    modport master (
        output mem_addr,
        input  mem_rdata,
        output char_addr,
        output char_data,
        output char_we
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        input  char_addr,
        input  char_data,
        input  char_we
    );

endinterface

// File: rtl/ascii_scanner_bcd_shift_unit.sv
// rtl/ascii_scanner_bcd_shift_unit.sv - multi-cycle double-dabble binary to BCD converter
module bcd_shift_unit #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_W-1:0]     load_value,
    output logic [DIGITS*4-1:0]   digits
);

    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [DIGITS*4-1:0] bcd_q, bcd_d;
    logic [DIGITS*4-1:0] adj;

    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        adj   = bcd_q;
        if (load) begin
            bin_d = load_value;
            bcd_d = '0;
        end else if (step) begin
            // Correct every digit that would overflow past 9 once doubled.
            for (int i = 0; i < DIGITS; i++) begin
                if (bcd_q[i*4 +: 4] >= 4'd5) begin
                    adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
                end
            end
            {bcd_d, bin_d} = {adj[DIGITS*4-2:0], bin_q, 1'b0};
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bin_q <= '0;
            bcd_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
        end
    end

    assign digits = bcd_q;

endmodule

// File: rtl/ascii_scanner.sv
// rtl/ascii_scanner.sv - sweeps data memory, writes each word as a signed/unsigned decimal ASCII field
// Optional two's complement input handling: define ASCII_SCANNER_SIGNED_EN.
module ascii_scanner
    import ascii_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5,
    parameter int WORDS  = 32
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    ascii_scanner_if.master bus
);

    localparam int FW = DIGITS + 1;
    localparam int IW = $clog2(WORDS);
    localparam int CW = $clog2(WORDS * FW);
    localparam int NW = $clog2(DATA_W + FW + 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   index_q, index_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            char_we_q, char_we_d;
    logic [CW-1:0]   char_addr_q, char_addr_d;
    logic [7:0]      char_data_q, char_data_d;
    logic [IW-1:0]   mem_addr_q, mem_addr_d;

    logic [DATA_W-1:0]   load_value;
    logic [DIGITS*4-1:0] digits;
    logic [7:0]          sign_char;
    logic [3:0]          digit_sel;
    int                  pos;

`ifdef ASCII_SCANNER_SIGNED_EN
    logic neg_q, neg_d;

    // Two's complement negate; the most-negative value maps onto itself, read as unsigned.
    assign load_value = bus.mem_rdata[DATA_W-1]
                      ? ((~bus.mem_rdata) + {{(DATA_W-1){1'b0}}, 1'b1})
                      : bus.mem_rdata;
    assign sign_char  = neg_q ? ASCII_MINUS : ASCII_SPACE;

    always_comb begin
        neg_d = neg_q;
        if (state_q == ST_LOAD) begin
            neg_d = bus.mem_rdata[DATA_W-1];
        end
    end
`else
    assign load_value = bus.mem_rdata;
    assign sign_char  = ASCII_SPACE;
`endif

    bcd_shift_unit #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bcd (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .load       (state_q == ST_LOAD),
        .step       (state_q == ST_CONVERT),
        .load_value (load_value),
        .digits     (digits)
    );

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    index_d = '0;
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: state_d = ST_LOAD;
            ST_LOAD: begin
                state_d = ST_CONVERT;
                cnt_d   = '0;
            end
            ST_CONVERT: begin
                if (cnt_q == NW'(DATA_W - 1)) begin
                    state_d = ST_EMIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (cnt_q == NW'(DIGITS)) begin
                    if (index_q == IW'(WORDS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = ST_READ;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are derived from the next state so they line up with it once registered.
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        char_we_d   = (state_d == ST_EMIT);
        mem_addr_d  = index_d;
        char_addr_d = '0;
        char_data_d = '0;
        digit_sel   = '0;
        pos         = int'(cnt_d);
        if (char_we_d) begin
            char_addr_d = CW'(int'(index_d) * FW + pos);
            if (pos == 0) begin
                char_data_d = sign_char;
            end else begin
                if (pos <= DIGITS) begin
                    digit_sel = digits[(DIGITS - pos)*4 +: 4];
                end
                char_data_d = ASCII_ZERO + {4'b0000, digit_sel};
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            char_we_q   <= 1'b0;
            char_addr_q <= '0;
            char_data_q <= '0;
            mem_addr_q  <= '0;
`ifdef ASCII_SCANNER_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            char_we_q   <= char_we_d;
            char_addr_q <= char_addr_d;
            char_data_q <= char_data_d;
            mem_addr_q  <= mem_addr_d;
`ifdef ASCII_SCANNER_SIGNED_EN
            neg_q       <= neg_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.char_we   = char_we_q;
    assign bus.char_addr = char_addr_q;
    assign bus.char_data = char_data_q;

endmodule

// File: tb/tb_ascii_scanner.sv
// tb/tb_ascii_scanner.sv - randomized self-checking bench for ascii_scanner against a decimal reference
module tb_ascii_scanner;

    localparam int DATA_W = 16;
    localparam int DIGITS = 5;
    localparam int WORDS  = 32;
    localparam int FW     = DIGITS + 1;
    localparam int NCH    = WORDS * FW;
    localparam int WLAT   = DATA_W + DIGITS + 4;
    localparam int SWEEP  = WORDS * WLAT;

    logic CLOCK_50 = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;

    ascii_scanner_if #(.DATA_W(DATA_W), .DIGITS(DIGITS), .WORDS(WORDS)) bus ();

    ascii_scanner #(.DATA_W(DATA_W), .DIGITS(DIGITS), .WORDS(WORDS)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    logic [DATA_W-1:0] mem [WORDS];
    logic [7:0]        cbuf [NCH];
    logic [FW*8-1:0]   exp_field [WORDS];
    int wr_cnt     = 0;
    int oob_cnt    = 0;
    int first_addr = -1;
    int n_checks   = 0;
    int n_errors   = 0;

    // Synchronous RAM and character buffer models.
    always @(posedge CLOCK_50) begin
        bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.char_we === 1'b1) begin
            wr_cnt = wr_cnt + 1;
            if (first_addr < 0) first_addr = int'(bus.char_addr);
            if (int'(bus.char_addr) >= NCH) oob_cnt = oob_cnt + 1;
            else cbuf[bus.char_addr] = bus.char_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW*8-1:0] ref_field(input logic [DATA_W-1:0] w);
        logic [FW*8-1:0] f;
        int mag;
        int pw;
        mag = int'(w);
        f[FW*8-1 -: 8] = 8'h20;
`ifdef ASCII_SCANNER_SIGNED_EN
        if (w[DATA_W-1]) begin
            f[FW*8-1 -: 8] = 8'h2D;
            mag = (1 << DATA_W) - int'(w);
        end
`endif
        for (int q = 1; q <= DIGITS; q++) begin
            pw = 1;
            for (int k = 0; k < DIGITS - q; k++) pw = pw * 10;
            f[(FW-1-q)*8 +: 8] = 8'h30 + 8'((mag / pw) % 10);
        end
        return f;
    endfunction

    function automatic logic [FW*8-1:0] got_field(input int i);
        logic [FW*8-1:0] f;
        for (int q = 0; q < FW; q++) f[(FW-1-q)*8 +: 8] = cbuf[i*FW + q];
        return f;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < WORDS; i++) begin
            case ($urandom_range(0, 4))
                0:       mem[i] = '0;
                1:       mem[i] = '1;
                2:       mem[i] = {1'b1, {(DATA_W-1){1'b0}}};
                default: mem[i] = DATA_W'($urandom);
            endcase
        end
    endtask

    task automatic prepare();
        for (int i = 0; i < WORDS; i++) exp_field[i] = ref_field(mem[i]);
        for (int c = 0; c < NCH; c++) cbuf[c] = 8'hFF;
        wr_cnt     = 0;
        first_addr = -1;
    endtask

    task automatic check_fields(input string tag);
        for (int i = 0; i < WORDS; i++)
            check($sformatf("%s_field%0d", tag, i), 64'(got_field(i)), 64'(exp_field[i]));
        check({tag, "_writes"}, 64'(wr_cnt), 64'(NCH));
        check({tag, "_oob"}, 64'(oob_cnt), 64'd0);
    endtask

    task automatic run_sweep(input string tag, input int perturb_at);
        int n, busy_cycles, done_at, done_cnt, idle_at;
        prepare();
        @(negedge CLOCK_50) start = 1'b1;
        @(negedge CLOCK_50) start = 1'b0;
        n = 0; busy_cycles = 0; done_at = -1; done_cnt = 0; idle_at = -1;
        while (idle_at < 0 && n < SWEEP + 100) begin
            if (busy) busy_cycles++;
            else idle_at = n;
            if (done) begin
                done_cnt++;
                done_at = n;
            end
            if (n == perturb_at) mem[0] = ~mem[0];
            @(negedge CLOCK_50);
            n++;
        end
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(SWEEP + 1));
        check({tag, "_done_at"}, 64'(done_at), 64'(SWEEP));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_idle_at"}, 64'(idle_at), 64'(SWEEP + 1));
        check({tag, "_first_addr"}, 64'(first_addr), 64'd0);
        check_fields(tag);
    endtask

    initial begin
        int lows, low1, low2, dones, t;
        for (int i = 0; i < WORDS; i++) mem[i] = '0;
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_we", 64'(bus.char_we), 64'd0);
        check("rst_char_addr", 64'(bus.char_addr), 64'd0);
        check("rst_char_data", 64'(bus.char_data), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        check("idle_after_rst", 64'(busy), 64'd0);

        fill_random();
        mem[0]  = 16'd1234;
        mem[1]  = 16'd0;
        mem[3]  = 16'hFFFF;
        mem[31] = 16'h8000;
        run_sweep("s1", -1);
        run_sweep("s2", -1);
        fill_random();
        run_sweep("s3", 10);
        fill_random();
        run_sweep("s4", -1);

        // Abort during CONVERT of word 5.
        fill_random();
        prepare();
        @(negedge CLOCK_50) start = 1'b1;
        @(negedge CLOCK_50) start = 1'b0;
        repeat (5 * WLAT + 8) @(negedge CLOCK_50);
        check("abort_writes_before", 64'(wr_cnt), 64'(5 * FW));
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_we", 64'(bus.char_we), 64'd0);
        wr_cnt = 0;
        repeat (60) @(negedge CLOCK_50);
        check("abort_writes_after", 64'(wr_cnt), 64'd0);
        check("abort_still_idle", 64'(busy), 64'd0);
        fill_random();
        run_sweep("s5", -1);

        // Start held high: back-to-back sweeps separated by one IDLE cycle.
        prepare();
        lows = 0; low1 = -1; low2 = -1; dones = 0;
        @(negedge CLOCK_50) start = 1'b1;
        @(negedge CLOCK_50);
        for (int n = 0; n < 2000; n++) begin
            if (!busy) begin
                lows++;
                if (low1 < 0) low1 = n;
                else if (low2 < 0) low2 = n;
            end
            if (done) dones++;
            @(negedge CLOCK_50);
        end
        start = 1'b0;
        check("held_idle_cycles", 64'(lows), 64'd2);
        check("held_idle1", 64'(low1), 64'(SWEEP + 1));
        check("held_idle2", 64'(low2), 64'(2 * (SWEEP + 2) - 1));
        check("held_dones", 64'(dones), 64'd2);
        t = 0;
        while (busy && t < SWEEP + 100) begin
            @(negedge CLOCK_50);
            t++;
        end
        check("held_final_idle", 64'(busy), 64'd0);
        check("held_oob", 64'(oob_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ascii_scanner.md
ASCII_SCANNER -- requirements
Module: ascii_scanner

Interface
REQ-001 Parameter DATA_W, default 16: width of one data-memory word.
REQ-002 Parameter DIGITS, default 5: decimal digits per field; 10^DIGITS SHALL exceed 2^DATA_W-1.
REQ-003 Parameter WORDS, default 32: data-memory words scanned per sweep.
REQ-004 CLOCK_50  in  1  system clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start  in  1  request one full sweep; sampled only in IDLE.
REQ-007 mem_addr  out  clog2(WORDS)  data-memory read address.
REQ-008 mem_rdata  in  DATA_W  word at mem_addr, valid one cycle after mem_addr is presented (synchronous RAM).
REQ-009 char_addr  out  clog2(WORDS*(DIGITS+1))  character-buffer write address.
REQ-010 char_data  out  8  ASCII code to write.
REQ-011 char_we  out  1  character-buffer write strobe, one character per cycle.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  single-cycle pulse at sweep completion.

Function
REQ-014 States SHALL be IDLE, READ, WAIT, LOAD, CONVERT, EMIT, DONE.
REQ-015 IDLE->READ when start=1; word index SHALL clear to 0.
REQ-016 READ drives mem_addr=index (1 cycle); WAIT covers RAM latency (1 cycle); LOAD captures mem_rdata (1 cycle).
REQ-017 CONVERT SHALL run a double-dabble shift-add for exactly DATA_W cycles, yielding DIGITS BCD digits.
REQ-018 EMIT SHALL run exactly DIGITS+1 cycles with char_we=1: first the sign char, then digits MSD first.
REQ-019 Field layout: char_addr = index*(DIGITS+1) + position, position 0 = sign.
REQ-020 Digit chars SHALL be 0x30+digit; leading zeros SHALL be printed as '0' (no blanking).
REQ-021 After EMIT: index<WORDS-1 -> increment index, go to READ; index=WORDS-1 -> DONE.
REQ-022 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-023 Per-word latency SHALL be DATA_W+DIGITS+4 cycles (25 at defaults); sweep = WORDS*(DATA_W+DIGITS+4)+1 cycles incl. DONE.
REQ-024 mem_rdata changes after LOAD SHALL NOT affect the field in progress.
REQ-025 start while busy SHALL be ignored; start held high SHALL launch a new sweep only from IDLE.
REQ-026 Index wraps never: exactly WORDS fields written per sweep, no writes outside 0..WORDS*(DIGITS+1)-1.

Reset
REQ-027 reset SHALL force IDLE, index=0, busy=0, done=0, char_we=0, char_addr=0, char_data=0, mem_addr=0 at the next edge.
REQ-028 reset mid-sweep SHALL abort with no further char_we; reset and start together -> reset wins.

Configuration
REQ-029 Macro ASCII_SCANNER_SIGNED_EN defined: mem_rdata is two's complement; negative -> sign '-' (0x2D) and magnitude converted, most-negative value converted as unsigned 2^(DATA_W-1).
REQ-030 Macro undefined: mem_rdata is unsigned; sign char always ' ' (0x20); negation logic not compiled.

Structure
REQ-031 Package ascii_pkg SHALL hold the state enum and ASCII constants (space 0x20, minus 0x2D, zero 0x30).
REQ-032 One sub-module, bcd_shift_unit, SHALL implement the DATA_W-cycle double-dabble (load, step, digits out).

Verification
REQ-033 mem[0]=16'd1234, start -> chars 0..5 = 0x20,0x30,0x31,0x32,0x33,0x34.
REQ-034 mem[3]=16'hFFFF -> chars 18..23 "-00001" with SIGNED_EN; " 65535" without.
REQ-035 mem[31]=16'h8000, SIGNED_EN -> chars 186..191 "-32768"; mem[1]=0 -> chars 6..11 " 00000".
REQ-036 start pulse at edge k -> busy from k, exactly 192 char_we cycles, done high only in cycle k+800, busy low from k+801.
REQ-037 reset asserted during CONVERT of word 5 -> busy=0 next cycle, zero later writes; new start rewrites from char_addr 0.
REQ-038 start held high for 2000 cycles -> back-to-back sweeps, each separated by exactly one IDLE cycle.
